reorder_buffer: RTL and testbench

In-order commit buffer directly downstream of the reservation station. It allocates one entry per dispatched instruction and captures ALU/branch/jalr results from the reservation station and load/store results from the load-store buffer. It serves operand lookups to the dispatcher and retires at most one instruction per cycle to the register file or the store path. It also detects branch and jalr mispredictions and raises the global `flush_signal`.

---
 rtl/reorder_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer sitting after the reservation station.
// Entries are allocated at dispatch, completed out of order by RS/LSB writebacks,
// and retired in order, one per cycle. Branch/jalr mispredictions raise a flush.
module reorder_buffer #(
  parameter int RoB_WIDTH = 4,
  parameter int RoB_SIZE  = 1 << RoB_WIDTH,
  parameter int NON_DEP   = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [31:0]          alloc_target,
  input  logic                 alloc_data_ready,
  input  logic [31:0]          alloc_data,
  output logic [RoB_WIDTH-1:0] alloc_index,
  output logic                 isFull,
  output logic                 isEmpty,
  input  logic                 RS_update_en,
  input  logic [RoB_WIDTH-1:0] RS_update_index,
  input  logic [31:0]          RS_update_data,
  input  logic                 LSB_update_en,
  input  logic [RoB_WIDTH-1:0] LSB_update_index,
  input  logic [31:0]          LSB_update_data,
  input  logic [RoB_WIDTH-1:0] query_j_index,
  input  logic [RoB_WIDTH-1:0] query_k_index,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  output logic                 commit_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic [RoB_WIDTH-1:0] commit_index,
  output logic                 store_commit_en,
  output logic [RoB_WIDTH-1:0] store_commit_index,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc
);

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_JALR   = 2'd3
  } entry_kind_t;

  // Capacity can never exceed the tag space; NON_DEP is the first tag outside it.
  localparam logic [RoB_WIDTH:0]   FULL_COUNT =
    (RoB_WIDTH+1)'((RoB_SIZE < NON_DEP) ? RoB_SIZE : NON_DEP);
  localparam logic [RoB_WIDTH:0]   COUNT_ONE  = (RoB_WIDTH+1)'(1);
  localparam logic [RoB_WIDTH-1:0] IDX_ONE    = (RoB_WIDTH)'(1);

  logic        busy_q   [RoB_SIZE];
  logic        ready_q  [RoB_SIZE];
  entry_kind_t kind_q   [RoB_SIZE];
  logic [4:0]  rd_q     [RoB_SIZE];
  logic [31:0] pc_q     [RoB_SIZE];
  logic        pred_q   [RoB_SIZE];
  logic [31:0] target_q [RoB_SIZE];
  logic [31:0] data_q   [RoB_SIZE];

  logic [RoB_WIDTH-1:0] head_q;
  logic [RoB_WIDTH-1:0] tail_q;
  logic [RoB_WIDTH:0]   count_q;

  logic alloc_ok;
  logic commit_ok;

  assign isFull      = (count_q == FULL_COUNT);
  assign isEmpty     = (count_q == '0);
  assign alloc_index = tail_q;
  assign alloc_ok    = alloc_en && !isFull;
  assign commit_ok   = busy_q[head_q] && ready_q[head_q];

  // Operand lookup: a writeback landing this cycle wins over the stored entry.
  always_comb begin
    query_j_ready = ready_q[query_j_index];
    query_j_data  = data_q[query_j_index];
    query_k_ready = ready_q[query_k_index];
    query_k_data  = data_q[query_k_index];
    if (RS_update_en && RS_update_index == query_j_index) begin
      query_j_ready = 1'b1;
      query_j_data  = RS_update_data;
    end else if (LSB_update_en && LSB_update_index == query_j_index) begin
      query_j_ready = 1'b1;
      query_j_data  = LSB_update_data;
    end
    if (RS_update_en && RS_update_index == query_k_index) begin
      query_k_ready = 1'b1;
      query_k_data  = RS_update_data;
    end else if (LSB_update_en && LSB_update_index == query_k_index) begin
      query_k_ready = 1'b1;
      query_k_data  = LSB_update_data;
    end
  end

  // Entry storage, pointers and registered commit/flush pulses; a pending flush
  // is applied even while stalled so a redirect is never lost.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        busy_q[i]   <= 1'b0;
        ready_q[i]  <= 1'b0;
        kind_q[i]   <= KIND_REG;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        pred_q[i]   <= 1'b0;
        target_q[i] <= '0;
        data_q[i]   <= '0;
      end
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      commit_en          <= 1'b0;
      commit_rd          <= '0;
      commit_data        <= '0;
      commit_index       <= '0;
      store_commit_en    <= 1'b0;
      store_commit_index <= '0;
      flush_signal       <= 1'b0;
      flush_pc           <= '0;
    end else begin
      commit_en       <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      if (flush_signal) begin
        for (int i = 0; i < RoB_SIZE; i++) begin
          busy_q[i] <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else if (rdy_in) begin
        if (alloc_ok) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= alloc_data_ready;
          kind_q[tail_q]   <= entry_kind_t'(alloc_type);
          rd_q[tail_q]     <= alloc_rd;
          pc_q[tail_q]     <= alloc_pc;
          pred_q[tail_q]   <= alloc_pred_taken;
          target_q[tail_q] <= alloc_target;
          data_q[tail_q]   <= alloc_data;
          tail_q           <= tail_q + IDX_ONE;
        end
        if (RS_update_en && busy_q[RS_update_index]) begin
          ready_q[RS_update_index] <= 1'b1;
          data_q[RS_update_index]  <= RS_update_data;
        end
        if (LSB_update_en && busy_q[LSB_update_index]) begin
          ready_q[LSB_update_index] <= 1'b1;
          data_q[LSB_update_index]  <= LSB_update_data;
        end
        if (commit_ok) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + IDX_ONE;
          commit_index   <= head_q;
          case (kind_q[head_q])
            KIND_REG: begin
              commit_en   <= (rd_q[head_q] != 5'd0);
              commit_rd   <= rd_q[head_q];
              commit_data <= data_q[head_q];
            end
            KIND_STORE: begin
              store_commit_en    <= 1'b1;
              store_commit_index <= head_q;
            end
            KIND_BRANCH: begin
              if (data_q[head_q][0] != pred_q[head_q]) begin
                flush_signal <= 1'b1;
                flush_pc     <= data_q[head_q][0] ? target_q[head_q]
                                                  : pc_q[head_q] + 32'd4;
              end
            end
            KIND_JALR: begin
              commit_en   <= (rd_q[head_q] != 5'd0);
              commit_rd   <= rd_q[head_q];
              commit_data <= pc_q[head_q] + 32'd4;
              if (data_q[head_q] != target_q[head_q]) begin
                flush_signal <= 1'b1;
                flush_pc     <= data_q[head_q];
              end
            end
            default: ;
          endcase
        end
        case ({alloc_ok, commit_ok})
          2'b10:   count_q <= count_q + COUNT_ONE;
          2'b01:   count_q <= count_q - COUNT_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors with hand-computed expectations for the
// reorder buffer (ordering, full/wrap, flush, jalr, bypass, store, stall).
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        alloc_en;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic        alloc_pred_taken;
  logic [31:0] alloc_target;
  logic        alloc_data_ready;
  logic [31:0] alloc_data;
  logic [3:0]  alloc_index;
  logic        isFull;
  logic        isEmpty;
  logic        RS_update_en;
  logic [3:0]  RS_update_index;
  logic [31:0] RS_update_data;
  logic        LSB_update_en;
  logic [3:0]  LSB_update_index;
  logic [31:0] LSB_update_data;
  logic [3:0]  query_j_index;
  logic [3:0]  query_k_index;
  logic        query_j_ready;
  logic        query_k_ready;
  logic [31:0] query_j_data;
  logic [31:0] query_k_data;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [3:0]  commit_index;
  logic        store_commit_en;
  logic [3:0]  store_commit_index;
  logic        flush_signal;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.RoB_WIDTH(4)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .alloc_en           (alloc_en),
    .alloc_type         (alloc_type),
    .alloc_rd           (alloc_rd),
    .alloc_pc           (alloc_pc),
    .alloc_pred_taken   (alloc_pred_taken),
    .alloc_target       (alloc_target),
    .alloc_data_ready   (alloc_data_ready),
    .alloc_data         (alloc_data),
    .alloc_index        (alloc_index),
    .isFull             (isFull),
    .isEmpty            (isEmpty),
    .RS_update_en       (RS_update_en),
    .RS_update_index    (RS_update_index),
    .RS_update_data     (RS_update_data),
    .LSB_update_en      (LSB_update_en),
    .LSB_update_index   (LSB_update_index),
    .LSB_update_data    (LSB_update_data),
    .query_j_index      (query_j_index),
    .query_k_index      (query_k_index),
    .query_j_ready      (query_j_ready),
    .query_k_ready      (query_k_ready),
    .query_j_data       (query_j_data),
    .query_k_data       (query_k_data),
    .commit_en          (commit_en),
    .commit_rd          (commit_rd),
    .commit_data        (commit_data),
    .commit_index       (commit_index),
    .store_commit_en    (store_commit_en),
    .store_commit_index (store_commit_index),
    .flush_signal       (flush_signal),
    .flush_pc           (flush_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One clock edge with whatever is currently driven, then drop the strobes.
  task automatic applyStimulus();
    @(posedge clk_in);
    #1;
    alloc_en      = 1'b0;
    RS_update_en  = 1'b0;
    LSB_update_en = 1'b0;
  endtask

  task automatic driveAlloc(input logic [1:0] kind, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pred,
                            input logic [31:0] target, input logic dready,
                            input logic [31:0] dval);
    alloc_en         = 1'b1;
    alloc_type       = kind;
    alloc_rd         = rd;
    alloc_pc         = pc;
    alloc_pred_taken = pred;
    alloc_target     = target;
    alloc_data_ready = dready;
    alloc_data       = dval;
  endtask

  task automatic driveRs(input logic [3:0] idx, input logic [31:0] val);
    RS_update_en    = 1'b1;
    RS_update_index = idx;
    RS_update_data  = val;
  endtask

  task automatic driveLsb(input logic [3:0] idx, input logic [31:0] val);
    LSB_update_en    = 1'b1;
    LSB_update_index = idx;
    LSB_update_data  = val;
  endtask

  task automatic resetDut();
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    alloc_en = 1'b0; alloc_type = '0; alloc_rd = '0; alloc_pc = '0;
    alloc_pred_taken = 1'b0; alloc_target = '0; alloc_data_ready = 1'b0; alloc_data = '0;
    RS_update_en = 1'b0; RS_update_index = '0; RS_update_data = '0;
    LSB_update_en = 1'b0; LSB_update_index = '0; LSB_update_data = '0;
    query_j_index = '0; query_k_index = '0;

    #12;
    checkOutput("rst_isEmpty", isEmpty, 1);
    checkOutput("rst_isFull", isFull, 0);
    checkOutput("rst_alloc_index", alloc_index, 0);
    checkOutput("rst_commit_en", commit_en, 0);
    checkOutput("rst_store_commit_en", store_commit_en, 0);
    checkOutput("rst_flush_signal", flush_signal, 0);
    checkOutput("rst_flush_pc", flush_pc, 0);
    checkOutput("rst_commit_data", commit_data, 0);
    #2;
    rst_in = 1'b1;

    // Out-of-order writebacks, in-order commits
    driveAlloc(2'd0, 5'd1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0); applyStimulus();
    driveAlloc(2'd0, 5'd2, 32'h1004, 1'b0, 32'h0, 1'b0, 32'h0); applyStimulus();
    driveAlloc(2'd0, 5'd3, 32'h1008, 1'b0, 32'h0, 1'b0, 32'h0); applyStimulus();
    checkOutput("t1_alloc_index", alloc_index, 3);
    checkOutput("t1_isEmpty", isEmpty, 0);
    driveRs(4'd2, 32'h22); applyStimulus();
    checkOutput("t1_no_commit_idx2_first", commit_en, 0);
    driveRs(4'd0, 32'h11); applyStimulus();
    checkOutput("t1_commit_latency", commit_en, 0);
    driveRs(4'd1, 32'h33); applyStimulus();
    checkOutput("t1_c0_en", commit_en, 1);
    checkOutput("t1_c0_rd", commit_rd, 1);
    checkOutput("t1_c0_data", commit_data, 32'h11);
    checkOutput("t1_c0_index", commit_index, 0);
    applyStimulus();
    checkOutput("t1_c1_en", commit_en, 1);
    checkOutput("t1_c1_rd", commit_rd, 2);
    checkOutput("t1_c1_data", commit_data, 32'h33);
    checkOutput("t1_c1_index", commit_index, 1);
    applyStimulus();
    checkOutput("t1_c2_rd", commit_rd, 3);
    checkOutput("t1_c2_data", commit_data, 32'h22);
    checkOutput("t1_c2_index", commit_index, 2);
    checkOutput("t1_empty_after", isEmpty, 1);
    applyStimulus();
    checkOutput("t1_commit_pulse_drops", commit_en, 0);

    // Fill, refuse, commit-while-full, wrap
    resetDut();
    for (int i = 0; i < 16; i++) begin
      driveAlloc(2'd0, 5'd5, 32'h2000, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus();
    end
    checkOutput("t2_isFull", isFull, 1);
    checkOutput("t2_alloc_index_wrapped", alloc_index, 0);
    driveAlloc(2'd0, 5'd6, 32'h2100, 1'b0, 32'h0, 1'b1, 32'hBAD);
    applyStimulus();
    checkOutput("t2_17th_isFull", isFull, 1);
    checkOutput("t2_17th_alloc_index", alloc_index, 0);
    query_j_index = 4'd0;
    #1;
    checkOutput("t2_17th_not_written", query_j_ready, 0);
    driveRs(4'd0, 32'hA0); applyStimulus();
    checkOutput("t2_wb_no_commit_yet", commit_en, 0);
    driveAlloc(2'd0, 5'd7, 32'h2200, 1'b0, 32'h0, 1'b1, 32'h77);
    applyStimulus();
    checkOutput("t2_commit_en", commit_en, 1);
    checkOutput("t2_commit_data", commit_data, 32'hA0);
    checkOutput("t2_full_alloc_refused", alloc_index, 0);
    checkOutput("t2_not_full", isFull, 0);
    driveAlloc(2'd0, 5'd7, 32'h2200, 1'b0, 32'h0, 1'b1, 32'h77);
    applyStimulus();
    checkOutput("t2_wrap_alloc_index", alloc_index, 1);
    checkOutput("t2_wrap_isFull", isFull, 1);
    checkOutput("t2_wrap_no_commit", commit_en, 0);
    #1;
    checkOutput("t2_idx0_ready", query_j_ready, 1);
    checkOutput("t2_idx0_data", query_j_data, 32'h77);

    // Branch misprediction flush
    resetDut();
    driveAlloc(2'd1, 5'd0, 32'h100, 1'b0, 32'h200, 1'b0, 32'h0); applyStimulus();
    driveRs(4'd0, 32'd1); applyStimulus();
    checkOutput("t3_no_flush_yet", flush_signal, 0);
    applyStimulus();
    checkOutput("t3_flush", flush_signal, 1);
    checkOutput("t3_flush_pc", flush_pc, 32'h200);
    checkOutput("t3_branch_no_regwrite", commit_en, 0);
    checkOutput("t3_alloc_index_before", alloc_index, 1);
    driveAlloc(2'd0, 5'd4, 32'h104, 1'b0, 32'h0, 1'b1, 32'h44);
    applyStimulus();
    checkOutput("t3_flush_pulse", flush_signal, 0);
    checkOutput("t3_isEmpty", isEmpty, 1);
    checkOutput("t3_alloc_dropped", alloc_index, 0);
    applyStimulus();
    checkOutput("t3_still_empty", isEmpty, 1);
    driveAlloc(2'd1, 5'd0, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0); applyStimulus();
    driveRs(4'd0, 32'd1); applyStimulus();
    applyStimulus();
    checkOutput("t3_correct_pred_no_flush", flush_signal, 0);
    checkOutput("t3_correct_pred_retired", isEmpty, 1);
    driveAlloc(2'd1, 5'd0, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0); applyStimulus();
    driveRs(4'd1, 32'd0); applyStimulus();
    applyStimulus();
    checkOutput("t3_nt_flush", flush_signal, 1);
    checkOutput("t3_nt_flush_pc", flush_pc, 32'h504);
    checkOutput("t3_nt_index", commit_index, 1);

    // Jalr misprediction
    resetDut();
    driveAlloc(2'd3, 5'd1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h0); applyStimulus();
    driveRs(4'd0, 32'h90); applyStimulus();
    applyStimulus();
    checkOutput("t4_commit_en", commit_en, 1);
    checkOutput("t4_commit_rd", commit_rd, 1);
    checkOutput("t4_commit_data", commit_data, 32'h44);
    checkOutput("t4_flush", flush_signal, 1);
    checkOutput("t4_flush_pc", flush_pc, 32'h90);
    applyStimulus();
    checkOutput("t4_flush_pulse", flush_signal, 0);
    checkOutput("t4_commit_pulse", commit_en, 0);

    // Same-cycle writeback bypass on queries
    resetDut();
    for (int i = 0; i < 6; i++) begin
      driveAlloc(2'd0, 5'(i + 1), 32'h3000, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus();
    end
    query_j_index = 4'd5;
    query_k_index = 4'd4;
    #1;
    checkOutput("t5_j_not_ready", query_j_ready, 0);
    checkOutput("t5_k_not_ready", query_k_ready, 0);
    driveRs(4'd5, 32'hDEAD);
    driveLsb(4'd4, 32'hBEEF);
    #1;
    checkOutput("t5_j_bypass_ready", query_j_ready, 1);
    checkOutput("t5_j_bypass_data", query_j_data, 32'hDEAD);
    checkOutput("t5_k_bypass_ready", query_k_ready, 1);
    checkOutput("t5_k_bypass_data", query_k_data, 32'hBEEF);
    applyStimulus();
    #1;
    checkOutput("t5_j_stored_ready", query_j_ready, 1);
    checkOutput("t5_j_stored_data", query_j_data, 32'hDEAD);
    rst_in = 1'b0;
    #2;
    checkOutput("t5_async_rst_empty", isEmpty, 1);
    checkOutput("t5_async_rst_alloc_index", alloc_index, 0);
    checkOutput("t5_async_rst_ready", query_j_ready, 0);
    rst_in = 1'b1;

    // Store retire, stall, rd=0 reg-write
    driveAlloc(2'd2, 5'd0, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0); applyStimulus();
    driveAlloc(2'd0, 5'd0, 32'h704, 1'b0, 32'h0, 1'b1, 32'h55); applyStimulus();
    driveLsb(4'd0, 32'h1234); applyStimulus();
    rdy_in = 1'b0;
    applyStimulus();
    checkOutput("t6_stall_no_store", store_commit_en, 0);
    checkOutput("t6_stall_held_index", alloc_index, 2);
    checkOutput("t6_stall_not_empty", isEmpty, 0);
    rdy_in = 1'b1;
    applyStimulus();
    checkOutput("t6_store_commit_en", store_commit_en, 1);
    checkOutput("t6_store_commit_index", store_commit_index, 0);
    checkOutput("t6_store_no_regwrite", commit_en, 0);
    applyStimulus();
    checkOutput("t6_rd0_no_regwrite", commit_en, 0);
    checkOutput("t6_rd0_commit_index", commit_index, 1);
    checkOutput("t6_store_pulse", store_commit_en, 0);
    checkOutput("t6_empty", isEmpty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
